// File: rtl/seq_det_pkg.sv
// Elaboration-time helpers for the parametrised Mealy sequence detector:
// clog2, prefix-function transition lookup and overlap restart state.
package seq_det_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Bit i of the pattern as seen on the stream (i = 0 is the first bit sent).
  function automatic logic pat_bit(input logic [15:0] pattern, input int unsigned len,
                                   input int unsigned i);
    return pattern[len-1-i];
  endfunction

  // Longest j <= k+1 where the tail of (first k pattern bits, b) equals the pattern head.
  function automatic int unsigned next_state(input logic [15:0] pattern, input int unsigned len,
                                             input int unsigned k, input logic b);
    int unsigned best;
    logic        ok;
    logic        sb;
    best = 0;
    for (int unsigned j = 1; j <= k + 1; j++) begin
      if (j <= len) begin
        ok = 1'b1;
        for (int unsigned t = 0; t < j; t++) begin
          sb = ((k + 1 - j + t) == k) ? b : pat_bit(pattern, len, k + 1 - j + t);
          if (sb != pat_bit(pattern, len, t)) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  function automatic int unsigned overlap_restart(input logic [15:0] pattern,
                                                  input int unsigned len);
    int unsigned best;
    logic        ok;
    best = 0;
    for (int unsigned j = 1; j < len; j++) begin
      ok = 1'b1;
      for (int unsigned t = 0; t < j; t++) begin
        if (pat_bit(pattern, len, t) != pat_bit(pattern, len, len - j + t)) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module seq_det_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_det_mealy_param.sv
// Parametrised Mealy serial sequence detector with registered match pulse.
// Optional saturating match counter enabled by SEQ_DET_MATCH_CNT_EN.
module seq_det_mealy_param
  import seq_det_pkg::*;
#(
  parameter int unsigned          PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0]   PATTERN = 5'b11011,
  parameter int unsigned          OVERLAP = 1,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
`ifdef SEQ_DET_MATCH_CNT_EN
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
`else
  output logic             out
`endif
);

  localparam int unsigned ST_W    = clog2(PAT_LEN);
  localparam logic [15:0] PAT16   = 16'(PATTERN);
  localparam int unsigned RESTART = (OVERLAP != 0) ? overlap_restart(PAT16, PAT_LEN) : 0;

  logic [ST_W-1:0] r_state;
  logic            r_out;
  logic [ST_W-1:0] w_next;
  logic            w_hit;
  logic [ST_W-1:0] w_ns0  [PAT_LEN];
  logic [ST_W-1:0] w_ns1  [PAT_LEN];
  logic            w_hit0 [PAT_LEN];
  logic            w_hit1 [PAT_LEN];

  // Transition table is fully constant; only the lookup remains in hardware.
  for (genvar gk = 0; gk < PAT_LEN; gk++) begin : g_tab
    localparam int unsigned J0 = next_state(PAT16, PAT_LEN, gk, 1'b0);
    localparam int unsigned J1 = next_state(PAT16, PAT_LEN, gk, 1'b1);
    assign w_ns0[gk]  = (J0 == PAT_LEN) ? ST_W'(RESTART) : ST_W'(J0);
    assign w_ns1[gk]  = (J1 == PAT_LEN) ? ST_W'(RESTART) : ST_W'(J1);
    assign w_hit0[gk] = (J0 == PAT_LEN);
    assign w_hit1[gk] = (J1 == PAT_LEN);
  end

  always_comb begin
    w_next = r_state;
    w_hit  = 1'b0;
    if (in_valid) begin
      if (32'(r_state) < PAT_LEN) begin
        w_next = in ? w_ns1[r_state]  : w_ns0[r_state];
        w_hit  = in ? w_hit1[r_state] : w_hit0[r_state];
      end else begin
        w_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_out   <= w_hit;
    end
  end

  assign out = r_out;

`ifdef SEQ_DET_MATCH_CNT_EN
  seq_det_sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_hit),
    .o_cnt (match_cnt)
  );
`endif

endmodule

// File: tb/tb_seq_det_mealy_param.sv
// Directed bench for seq_det_mealy_param across several pattern/overlap configurations.
module tb_seq_det_mealy_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic rst0 = 1'b0, in0 = 1'b0, v0 = 1'b0, out0;
  logic rst1 = 1'b0, in1 = 1'b0, v1 = 1'b0, out1;
  logic rst2 = 1'b0, in2 = 1'b0, v2 = 1'b0, out2;
  logic rst3 = 1'b0, in3 = 1'b0, v3 = 1'b0, out3;
`ifdef SEQ_DET_MATCH_CNT_EN
  logic [1:0] cnt0;
  logic [7:0] cnt1, cnt2, cnt3;
`endif

  seq_det_mealy_param #(.PAT_LEN(5), .PATTERN(5'b11011), .OVERLAP(1), .CNT_W(2)) d0 (
    .clk(clk), .rst(rst0), .in(in0), .in_valid(v0),
`ifdef SEQ_DET_MATCH_CNT_EN
    .match_cnt(cnt0),
`endif
    .out(out0));

  seq_det_mealy_param #(.PAT_LEN(5), .PATTERN(5'b11011), .OVERLAP(0)) d1 (
    .clk(clk), .rst(rst1), .in(in1), .in_valid(v1),
`ifdef SEQ_DET_MATCH_CNT_EN
    .match_cnt(cnt1),
`endif
    .out(out1));

  seq_det_mealy_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1)) d2 (
    .clk(clk), .rst(rst2), .in(in2), .in_valid(v2),
`ifdef SEQ_DET_MATCH_CNT_EN
    .match_cnt(cnt2),
`endif
    .out(out2));

  seq_det_mealy_param #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1)) d3 (
    .clk(clk), .rst(rst3), .in(in3), .in_valid(v3),
`ifdef SEQ_DET_MATCH_CNT_EN
    .match_cnt(cnt3),
`endif
    .out(out3));

  task automatic drive0(input logic r, input logic v, input logic b);
    rst0 = r; v0 = v; in0 = b;
    @(posedge clk); #1;
    rst0 = 1'b0; v0 = 1'b0;
  endtask

  task automatic drive_all_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    v0 = 1'b1; v1 = 1'b1; v2 = 1'b1; v3 = 1'b1;
    in0 = 1'b1; in1 = 1'b1; in2 = 1'b1; in3 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
  endtask

  task automatic test_reset();
    drive_all_reset();
    drive_all_reset();
    total++; if (out0 !== 1'b0) begin bad++; $display("FAIL reset_out0 got=%b exp=0", out0); end
    total++; if (out1 !== 1'b0) begin bad++; $display("FAIL reset_out1 got=%b exp=0", out1); end
    total++; if (out2 !== 1'b0) begin bad++; $display("FAIL reset_out2 got=%b exp=0", out2); end
    total++; if (out3 !== 1'b0) begin bad++; $display("FAIL reset_out3 got=%b exp=0", out3); end
    total++; if (d0.r_state !== 3'd0) begin bad++; $display("FAIL reset_state0 got=%0d exp=0", d0.r_state); end
`ifdef SEQ_DET_MATCH_CNT_EN
    total++; if (cnt0 !== 2'd0) begin bad++; $display("FAIL reset_cnt0 got=%0d exp=0", cnt0); end
`endif
  endtask

  task automatic test_overlap();
    logic [7:0] s, e;
    s = 8'b11011011; e = 8'b00001001;
    drive0(1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      drive0(1'b0, 1'b1, s[i]);
      total++;
      if (out0 !== e[i]) begin bad++; $display("FAIL overlap_bit%0d got=%b exp=%b", 8 - i, out0, e[i]); end
    end
  endtask

  task automatic test_nonoverlap();
    logic [7:0] s, e;
    s = 8'b11011011; e = 8'b00001000;
    rst1 = 1'b1; @(posedge clk); #1; rst1 = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      v1 = 1'b1; in1 = s[i];
      @(posedge clk); #1;
      v1 = 1'b0;
      total++;
      if (out1 !== e[i]) begin bad++; $display("FAIL nonoverlap_bit%0d got=%b exp=%b", 8 - i, out1, e[i]); end
    end
    total++; if (d1.r_state !== 3'd2) begin bad++; $display("FAIL nonoverlap_state got=%0d exp=2", d1.r_state); end
  endtask

  task automatic test_extra_ones();
    logic [6:0] s, e;
    logic [2:0] st [7];
    s = 7'b1111011; e = 7'b0000001;
    st = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd2};
    drive0(1'b1, 1'b0, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      drive0(1'b0, 1'b1, s[i]);
      total++;
      if (out0 !== e[i]) begin bad++; $display("FAIL ones_out_bit%0d got=%b exp=%b", 7 - i, out0, e[i]); end
      total++;
      if (d0.r_state !== st[6 - i]) begin bad++; $display("FAIL ones_state_bit%0d got=%0d exp=%0d", 7 - i, d0.r_state, st[6 - i]); end
    end
  endtask

  task automatic test_gap();
    drive0(1'b1, 1'b0, 1'b0);
    drive0(1'b0, 1'b1, 1'b1);
    drive0(1'b0, 1'b1, 1'b1);
    drive0(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive0(1'b0, 1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
      total++; if (d0.r_state !== 3'd3) begin bad++; $display("FAIL gap_state%0d got=%0d exp=3", i, d0.r_state); end
      total++; if (out0 !== 1'b0) begin bad++; $display("FAIL gap_out%0d got=%b exp=0", i, out0); end
    end
    drive0(1'b0, 1'b1, 1'b1);
    total++; if (out0 !== 1'b0) begin bad++; $display("FAIL gap_pre got=%b exp=0", out0); end
    drive0(1'b0, 1'b1, 1'b1);
    total++; if (out0 !== 1'b1) begin bad++; $display("FAIL gap_match got=%b exp=1", out0); end
    drive0(1'b0, 1'b0, 1'b0);
    total++; if (out0 !== 1'b0) begin bad++; $display("FAIL gap_post got=%b exp=0", out0); end
  endtask

  task automatic test_reset_mid();
    drive0(1'b1, 1'b0, 1'b0);
    drive0(1'b0, 1'b1, 1'b1);
    drive0(1'b0, 1'b1, 1'b1);
    drive0(1'b0, 1'b1, 1'b0);
    drive0(1'b0, 1'b1, 1'b1);
    total++; if (d0.r_state !== 3'd4) begin bad++; $display("FAIL rmid_pre got=%0d exp=4", d0.r_state); end
    drive0(1'b1, 1'b1, 1'b1);
    total++; if (d0.r_state !== 3'd0) begin bad++; $display("FAIL rmid_rst got=%0d exp=0", d0.r_state); end
    drive0(1'b0, 1'b1, 1'b1);
    total++; if (out0 !== 1'b0) begin bad++; $display("FAIL rmid_out got=%b exp=0", out0); end
    total++; if (d0.r_state !== 3'd1) begin bad++; $display("FAIL rmid_state got=%0d exp=1", d0.r_state); end
  endtask

  task automatic test_pat1010();
    logic [6:0] s, e;
    s = 7'b1010101; e = 7'b0001010;
    rst2 = 1'b1; @(posedge clk); #1; rst2 = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      v2 = 1'b1; in2 = s[i];
      @(posedge clk); #1;
      v2 = 1'b0;
      total++;
      if (out2 !== e[i]) begin bad++; $display("FAIL p1010_bit%0d got=%b exp=%b", 7 - i, out2, e[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    e = 3'b011;
    rst3 = 1'b1; @(posedge clk); #1; rst3 = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      v3 = 1'b1; in3 = 1'b1;
      @(posedge clk); #1;
      v3 = 1'b0;
      total++;
      if (out3 !== e[i]) begin bad++; $display("FAIL b2b_bit%0d got=%b exp=%b", 3 - i, out3, e[i]); end
    end
    @(posedge clk); #1;
    total++; if (out3 !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", out3); end
  endtask

`ifdef SEQ_DET_MATCH_CNT_EN
  task automatic test_match_cnt();
    logic [16:0] s;
    logic [1:0]  ec [5];
    int          m;
    s = 17'b11011011011011011;
    ec = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    m = 0;
    drive0(1'b1, 1'b0, 1'b0);
    total++; if (cnt0 !== 2'd0) begin bad++; $display("FAIL cnt_start got=%0d exp=0", cnt0); end
    for (int i = 16; i >= 0; i--) begin
      drive0(1'b0, 1'b1, s[i]);
      if (out0 === 1'b1 && m < 5) begin
        total++;
        if (cnt0 !== ec[m]) begin bad++; $display("FAIL cnt_match%0d got=%0d exp=%0d", m + 1, cnt0, ec[m]); end
        m++;
      end
    end
    total++; if (m !== 5) begin bad++; $display("FAIL cnt_matches got=%0d exp=5", m); end
    drive0(1'b1, 1'b0, 1'b0);
    total++; if (cnt0 !== 2'd0) begin bad++; $display("FAIL cnt_clear got=%0d exp=0", cnt0); end
  endtask
`endif

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_extra_ones();
    test_gap();
    test_reset_mid();
    test_pat1010();
    test_back_to_back();
`ifdef SEQ_DET_MATCH_CNT_EN
    test_match_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
